fpnew_opgroup_ordered_arbiter: RTL and testbench

Result collector for an operation-group block with several format slices of unequal latency. It replaces the stateless round-robin output arbitration with a parametrised arbiter. In ORDERED mode it records the slice index of every issued operation in a bounded FIFO and returns results strictly in issue order. In RR mode it arbitrates round-robin and keeps an in-flight count. It sits between the slice outputs and the opgroup output handshake; upstream gates its input ready with `issue_ready_o`.

---
 rtl/fpnew_pkg.sv | 15 +
 rtl/fpnew_idx_fifo.sv | 60 ++++++
 rtl/fpnew_opgroup_ordered_arbiter.sv | 139 +++++++++++++
 tb/tb_fpnew_opgroup_ordered_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared FPnew definitions used by the opgroup result collector and its
// index FIFO.
package fpnew_pkg;

  typedef enum logic {
    ORDERED = 1'b0,
    RR      = 1'b1
  } arb_mode_e;

  // Width of an index into n channels; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpnew_idx_fifo.sv
// Bounded FIFO of slice indices. Any depth is allowed, the pointers wrap
// explicitly, and a synchronous flush empties it.
module fpnew_idx_fifo #(
  parameter int unsigned  Depth    = 8,
  parameter int unsigned  Width    = 1,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] rd_ptr_q;
  logic [PtrWidth-1:0] wr_ptr_q;
  logic [CntWidth-1:0] count_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order in which the blocks are evaluated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntWidth'(1);
        2'b01:   count_q <= count_q - CntWidth'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset; an entry is
  // only read after it was written, and leaving it unreset keeps it a plain
  // register file instead of a bank of resettable flops.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fpnew_opgroup_ordered_arbiter.sv
// Result collector for an opgroup with slices of unequal latency: returns
// results in issue order (ORDERED) or round-robin (RR) and tracks in-flight ops.
module fpnew_opgroup_ordered_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned  NumIn    = 5,
  parameter int unsigned  Depth    = 8,
  parameter bit           Ordered  = 1'b1,
  parameter type          DataType = logic,
  localparam int unsigned IdxWidth = idx_width(NumIn),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic [IdxWidth-1:0] issue_idx_i,
  output logic                issue_ready_o,
  input  logic [NumIn-1:0]    slice_valid_i,
  input  DataType [NumIn-1:0] slice_data_i,
  output logic [NumIn-1:0]    slice_ready_o,
  output logic                out_valid_o,
  output DataType             out_data_o,
  output logic [IdxWidth-1:0] out_idx_o,
  input  logic                out_ready_i,
  output logic [CntWidth-1:0] inflight_o,
  output logic                busy_o
);

  localparam arb_mode_e         Mode   = Ordered ? ORDERED : RR;
  localparam logic [IdxWidth:0] NumInW = (IdxWidth + 1)'(NumIn);

  logic [CntWidth-1:0] count;
  logic [IdxWidth-1:0] head;
  logic                nonempty;
  logic                push;
  logic                pop;

  // Full is judged on the registered count only, so a pop never frees a slot
  // for an issue in the same cycle.
  assign issue_ready_o = (count != CntWidth'(Depth));
  assign nonempty      = (count != '0);
  assign push          = issue_valid_i & issue_ready_o & ~flush_i;
  assign pop           = out_valid_o & out_ready_i & ~flush_i;
  assign inflight_o    = count;
  assign busy_o        = nonempty;

  // In RR mode the stored indices are never read; only the count matters.
  fpnew_idx_fifo #(
    .Depth (Depth),
    .Width (IdxWidth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (issue_idx_i),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  logic [IdxWidth-1:0] rr_q;
  logic [IdxWidth-1:0] rr_pick;
  logic [IdxWidth-1:0] rr_grant;
  logic [IdxWidth-1:0] lock_idx_q;
  logic                lock_q;
  logic                rr_found;
  logic [IdxWidth:0]   cand;

  // First valid slice at or after rr_q, wrapping past NumIn-1 back to 0.
  always_comb begin
    rr_pick  = rr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NumIn; k++) begin
      cand = {1'b0, rr_q} + (IdxWidth + 1)'(k);
      if (cand >= NumInW) cand = cand - NumInW;
      if (!rr_found && slice_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand[IdxWidth-1:0];
      end
    end
  end

  // A stalled grant is pinned so a newly valid slice cannot steal the output
  // while downstream is back-pressuring.
  assign rr_grant = lock_q ? lock_idx_q : rr_pick;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (Mode == RR) begin
      if (pop) begin
        rr_q   <= (rr_grant == IdxWidth'(NumIn - 1)) ? '0 : rr_grant + IdxWidth'(1);
        lock_q <= 1'b0;
      end else if (out_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= rr_grant;
      end
    end
  end

  // NOTE: every output gets a default before any branch, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    out_valid_o   = 1'b0;
    out_data_o    = slice_data_i[0];
    out_idx_o     = '0;
    slice_ready_o = '0;
    if (Mode == ORDERED) begin
      out_valid_o = nonempty & slice_valid_i[head];
      out_data_o  = slice_data_i[head];
      out_idx_o   = nonempty ? head : '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        slice_ready_o[i] = out_ready_i & nonempty & (head == IdxWidth'(i));
      end
    end else begin
      out_valid_o = |slice_valid_i;
      out_data_o  = slice_data_i[rr_grant];
      out_idx_o   = rr_grant;
      for (int unsigned i = 0; i < NumIn; i++) begin
        slice_ready_o[i] = out_ready_i & (|slice_valid_i) & (rr_grant == IdxWidth'(i));
      end
    end
    // The slices drop their own state on flush, so nothing may hand off now.
    if (flush_i) begin
      out_valid_o   = 1'b0;
      slice_ready_o = '0;
    end
  end

endmodule

// File: tb/tb_fpnew_opgroup_ordered_arbiter.sv
// Directed bench: ordered return, full boundary, pointer wrap, round-robin
// grant/hold, flush and asynchronous mid-stream reset.
module tb_fpnew_opgroup_ordered_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: ordered, 3 slices, depth 4
  logic            a_flush, a_issue_valid, a_issue_ready, a_out_valid, a_out_ready, a_busy;
  logic [1:0]      a_issue_idx, a_out_idx;
  logic [2:0]      a_slice_valid, a_slice_ready, a_inflight;
  logic [2:0][7:0] a_slice_data;
  logic [7:0]      a_out_data;

  fpnew_opgroup_ordered_arbiter #(
    .NumIn (3), .Depth (4), .Ordered (1'b1), .DataType (logic [7:0])
  ) a_dut (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (a_flush),
    .issue_valid_i (a_issue_valid), .issue_idx_i (a_issue_idx), .issue_ready_o (a_issue_ready),
    .slice_valid_i (a_slice_valid), .slice_data_i (a_slice_data), .slice_ready_o (a_slice_ready),
    .out_valid_o (a_out_valid), .out_data_o (a_out_data), .out_idx_o (a_out_idx),
    .out_ready_i (a_out_ready), .inflight_o (a_inflight), .busy_o (a_busy)
  );

  // Instance B: ordered, 3 slices, depth 3 (non power of two)
  logic            b_flush, b_issue_valid, b_issue_ready, b_out_valid, b_out_ready, b_busy;
  logic [1:0]      b_issue_idx, b_out_idx, b_inflight;
  logic [2:0]      b_slice_valid, b_slice_ready;
  logic [2:0][7:0] b_slice_data;
  logic [7:0]      b_out_data;

  fpnew_opgroup_ordered_arbiter #(
    .NumIn (3), .Depth (3), .Ordered (1'b1), .DataType (logic [7:0])
  ) b_dut (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (b_flush),
    .issue_valid_i (b_issue_valid), .issue_idx_i (b_issue_idx), .issue_ready_o (b_issue_ready),
    .slice_valid_i (b_slice_valid), .slice_data_i (b_slice_data), .slice_ready_o (b_slice_ready),
    .out_valid_o (b_out_valid), .out_data_o (b_out_data), .out_idx_o (b_out_idx),
    .out_ready_i (b_out_ready), .inflight_o (b_inflight), .busy_o (b_busy)
  );

  // Instance C: round-robin, 4 slices, depth 8
  logic            c_flush, c_issue_valid, c_issue_ready, c_out_valid, c_out_ready, c_busy;
  logic [1:0]      c_issue_idx, c_out_idx;
  logic [3:0]      c_slice_valid, c_slice_ready, c_inflight;
  logic [3:0][7:0] c_slice_data;
  logic [7:0]      c_out_data;

  fpnew_opgroup_ordered_arbiter #(
    .NumIn (4), .Depth (8), .Ordered (1'b0), .DataType (logic [7:0])
  ) c_dut (
    .clk_i (clk), .rst_ni (rst_n), .flush_i (c_flush),
    .issue_valid_i (c_issue_valid), .issue_idx_i (c_issue_idx), .issue_ready_o (c_issue_ready),
    .slice_valid_i (c_slice_valid), .slice_data_i (c_slice_data), .slice_ready_o (c_slice_ready),
    .out_valid_o (c_out_valid), .out_data_o (c_out_data), .out_idx_o (c_out_idx),
    .out_ready_i (c_out_ready), .inflight_o (c_inflight), .busy_o (c_busy)
  );

  // Protocol monitors: no slice result without an op in flight, no RR pop from empty.
  always @(negedge clk) begin
    if (rst_n) begin
      check("a_proto", 32'((|a_slice_valid) && (a_inflight == 3'd0)), 0);
      check("b_proto", 32'((|b_slice_valid) && (b_inflight == 2'd0)), 0);
      check("c_proto", 32'(c_out_valid && c_out_ready && !c_flush && (c_inflight == 4'd0)), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [1:0] wrap_seq [10];

  initial begin
    wrap_seq = '{2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1};
    rst_n = 1'b0;
    {a_flush, a_issue_valid, a_issue_idx, a_slice_valid, a_slice_data, a_out_ready} = '0;
    {b_flush, b_issue_valid, b_issue_idx, b_slice_valid, b_slice_data, b_out_ready} = '0;
    {c_flush, c_issue_valid, c_issue_idx, c_slice_valid, c_slice_data, c_out_ready} = '0;
    #3;
    check("rst_a_issue_ready", 32'(a_issue_ready), 1);
    check("rst_a_inflight",    32'(a_inflight), 0);
    check("rst_a_busy",        32'(a_busy), 0);
    check("rst_a_out_valid",   32'(a_out_valid), 0);
    check("rst_a_slice_ready", 32'(a_slice_ready), 0);
    check("rst_a_out_idx",     32'(a_out_idx), 0);
    check("rst_c_out_idx",     32'(c_out_idx), 0);
    check("rst_c_issue_ready", 32'(c_issue_ready), 1);
    #20 rst_n = 1'b1;
    tick();

    // Ordered return: issue 2,0,1; slice 0 finishes first but must wait.
    a_issue_valid = 1'b1;
    a_issue_idx = 2'd2; tick();
    a_issue_idx = 2'd0; tick();
    a_issue_idx = 2'd1; tick();
    a_issue_valid = 1'b0;
    a_out_ready = 1'b1; a_slice_valid = 3'b001; a_slice_data[0] = 8'h10; #1;
    check("ord_hold_valid", 32'(a_out_valid), 0);
    check("ord_hold_ready", 32'(a_slice_ready), 'h4);
    check("ord_inflight3",  32'(a_inflight), 3);
    tick();
    check("ord_hold2_valid", 32'(a_out_valid), 0);
    check("ord_hold2_ready", 32'(a_slice_ready), 'h4);
    a_slice_valid = 3'b111; a_slice_data[1] = 8'h11; a_slice_data[2] = 8'h12; #1;
    check("ord_first_valid", 32'(a_out_valid), 1);
    check("ord_first_idx",   32'(a_out_idx), 2);
    check("ord_first_data",  32'(a_out_data), 'h12);
    tick();
    a_slice_valid = 3'b011; #1;
    check("ord_second_idx",   32'(a_out_idx), 0);
    check("ord_second_data",  32'(a_out_data), 'h10);
    check("ord_second_ready", 32'(a_slice_ready), 'h1);
    check("ord_second_infl",  32'(a_inflight), 2);
    tick();
    a_slice_valid = 3'b010; #1;
    check("ord_third_idx",   32'(a_out_idx), 1);
    check("ord_third_data",  32'(a_out_data), 'h11);
    check("ord_third_ready", 32'(a_slice_ready), 'h2);
    check("ord_third_infl",  32'(a_inflight), 1);
    tick();
    a_slice_valid = 3'b000; a_out_ready = 1'b0; #1;
    check("ord_done_infl",  32'(a_inflight), 0);
    check("ord_done_busy",  32'(a_busy), 0);
    check("ord_done_valid", 32'(a_out_valid), 0);

    // Full boundary: four issues, then pop + issue in the same cycle.
    a_issue_valid = 1'b1;
    a_issue_idx = 2'd0; tick();
    a_issue_idx = 2'd1; tick();
    a_issue_idx = 2'd2; tick();
    a_issue_idx = 2'd0; tick();
    a_issue_valid = 1'b0; #1;
    check("full_issue_ready", 32'(a_issue_ready), 0);
    check("full_inflight",    32'(a_inflight), 4);
    a_issue_valid = 1'b1; a_issue_idx = 2'd1;
    a_slice_valid = 3'b001; a_slice_data[0] = 8'h20; a_out_ready = 1'b1; #1;
    check("full_pop_valid",   32'(a_out_valid), 1);
    check("full_pop_idx",     32'(a_out_idx), 0);
    check("full_no_passthru", 32'(a_issue_ready), 0);
    tick();
    a_issue_valid = 1'b0; a_slice_valid = 3'b010; a_slice_data[1] = 8'h21; #1;
    check("full_after_infl",  32'(a_inflight), 3);
    check("full_after_ready", 32'(a_issue_ready), 1);
    check("full_drain1_idx",  32'(a_out_idx), 1);
    check("full_drain1_data", 32'(a_out_data), 'h21);
    tick();
    a_slice_valid = 3'b100; a_slice_data[2] = 8'h22; #1;
    check("full_drain2_idx",  32'(a_out_idx), 2);
    check("full_drain2_infl", 32'(a_inflight), 2);
    tick();
    a_slice_valid = 3'b001; a_slice_data[0] = 8'h23; #1;
    check("full_drain3_idx",  32'(a_out_idx), 0);
    check("full_drain3_data", 32'(a_out_data), 'h23);
    tick();
    a_slice_valid = 3'b000; a_out_ready = 1'b0; #1;
    check("full_empty_infl", 32'(a_inflight), 0);

    // Flush with three in flight: no handshake, no push, state cleared.
    a_issue_valid = 1'b1;
    a_issue_idx = 2'd1; tick();
    a_issue_idx = 2'd2; tick();
    a_issue_idx = 2'd0; tick();
    a_flush = 1'b1; a_issue_idx = 2'd2;
    a_slice_valid = 3'b010; a_slice_data[1] = 8'h30; a_out_ready = 1'b1; #1;
    check("flush_a_valid", 32'(a_out_valid), 0);
    check("flush_a_ready", 32'(a_slice_ready), 0);
    tick();
    a_flush = 1'b0; a_issue_valid = 1'b0; a_slice_valid = 3'b000; #1;
    check("flush_a_infl",  32'(a_inflight), 0);
    check("flush_a_busy",  32'(a_busy), 0);
    check("flush_a_issue", 32'(a_issue_ready), 1);
    a_issue_valid = 1'b1; a_issue_idx = 2'd2; tick();
    a_issue_valid = 1'b0; a_slice_valid = 3'b100; a_slice_data[2] = 8'h33; #1;
    check("flush_a_next_valid", 32'(a_out_valid), 1);
    check("flush_a_next_idx",   32'(a_out_idx), 2);
    check("flush_a_next_data",  32'(a_out_data), 'h33);
    tick();
    a_slice_valid = 3'b000; a_out_ready = 1'b0; #1;
    check("flush_a_next_infl", 32'(a_inflight), 0);

    // Wrap-around on depth 3: ten issues, each popped two cycles later.
    for (int t = 0; t < 12; t++) begin
      b_issue_valid = (t < 10);
      b_issue_idx   = (t < 10) ? wrap_seq[t] : 2'd0;
      b_slice_valid = 3'b000;
      b_out_ready   = 1'b0;
      if (t >= 2) begin
        b_slice_valid[wrap_seq[t-2]] = 1'b1;
        b_slice_data[wrap_seq[t-2]]  = 8'h40 + 8'(t - 2);
        b_out_ready = 1'b1;
      end
      #1;
      check("wrap_infl", 32'(b_inflight), (t == 0) ? 0 : (t == 1) ? 1 : (t <= 10) ? 2 : 1);
      check("wrap_issue_ready", 32'(b_issue_ready), 1);
      if (t >= 2) begin
        check("wrap_valid", 32'(b_out_valid), 1);
        check("wrap_idx",   32'(b_out_idx), 32'(wrap_seq[t-2]));
        check("wrap_data",  32'(b_out_data), 32'(8'h40 + 8'(t - 2)));
      end
      tick();
    end
    b_slice_valid = 3'b000; b_out_ready = 1'b0; #1;
    check("wrap_end_infl", 32'(b_inflight), 0);

    // Round-robin: fill, then all slices valid with ready high.
    c_issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_issue_idx = 2'(i);
      tick();
    end
    c_issue_valid = 1'b0; #1;
    check("rr_full_ready", 32'(c_issue_ready), 0);
    check("rr_full_infl",  32'(c_inflight), 8);
    c_slice_valid = 4'hF;
    for (int i = 0; i < 4; i++) c_slice_data[i] = 8'h50 + 8'(i);
    c_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_grant_idx",   32'(c_out_idx), k % 4);
      check("rr_grant_data",  32'(c_out_data), 'h50 + (k % 4));
      check("rr_grant_ready", 32'(c_slice_ready), 1 << (k % 4));
      tick();
    end
    c_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rr_hold_valid", 32'(c_out_valid), 1);
      check("rr_hold_idx",   32'(c_out_idx), 1);
      check("rr_hold_data",  32'(c_out_data), 'h51);
      check("rr_hold_ready", 32'(c_slice_ready), 0);
      check("rr_hold_infl",  32'(c_inflight), 3);
      tick();
    end
    c_flush = 1'b1; c_out_ready = 1'b1; #1;
    check("flush_c_valid", 32'(c_out_valid), 0);
    check("flush_c_ready", 32'(c_slice_ready), 0);
    tick();
    c_flush = 1'b0; c_out_ready = 1'b0; #1;
    check("flush_c_infl",  32'(c_inflight), 0);
    check("flush_c_busy",  32'(c_busy), 0);
    check("flush_c_issue", 32'(c_issue_ready), 1);
    c_issue_valid = 1'b1; c_issue_idx = 2'd0; tick(); tick();
    c_issue_valid = 1'b0; c_out_ready = 1'b1; #1;
    check("flush_c_rr0_idx",   32'(c_out_idx), 0);
    check("flush_c_rr0_ready", 32'(c_slice_ready), 1);
    tick();
    check("flush_c_rr1_idx", 32'(c_out_idx), 1);
    tick();
    c_out_ready = 1'b0; c_slice_valid = 4'h0; #1;
    check("rr_end_infl", 32'(c_inflight), 0);

    // Asynchronous reset in mid-stream, between clock edges.
    a_issue_valid = 1'b1;
    a_issue_idx = 2'd1; tick();
    a_issue_idx = 2'd2; tick();
    a_issue_valid = 1'b0; a_slice_valid = 3'b010; a_slice_data[1] = 8'h60; a_out_ready = 1'b1; #1;
    check("mid_pre_valid", 32'(a_out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(a_out_valid), 0);
    check("mid_rst_ready", 32'(a_slice_ready), 0);
    check("mid_rst_infl",  32'(a_inflight), 0);
    check("mid_rst_busy",  32'(a_busy), 0);
    check("mid_rst_issue", 32'(a_issue_ready), 1);
    check("mid_rst_idx",   32'(a_out_idx), 0);
    a_slice_valid = 3'b000; a_out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    a_issue_valid = 1'b1; a_issue_idx = 2'd2; tick();
    a_issue_valid = 1'b0; #1;
    check("post_rst_entry0", 32'(a_dut.u_idx_fifo.mem_q[0]), 2);
    check("post_rst_wrptr",  32'(a_dut.u_idx_fifo.wr_ptr_q), 1);
    check("post_rst_infl",   32'(a_inflight), 1);
    a_slice_valid = 3'b100; a_slice_data[2] = 8'h61; a_out_ready = 1'b1; #1;
    check("post_rst_idx",  32'(a_out_idx), 2);
    check("post_rst_data", 32'(a_out_data), 'h61);
    tick();
    a_slice_valid = 3'b000; a_out_ready = 1'b0; #1;
    check("post_rst_empty", 32'(a_inflight), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
